sram_ctl: RTL and testbench

SRAM_CTL -- requirements
Module: sram_ctl

---
 rtl/sram_ctl.sv | 141 ++++++++++++++
 tb/tb_sram_ctl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram_ctl                                                      |
// | Purpose  : Front-end controller for a simple dual-port RAM. After reset  |
// |            it zero-fills every word, then accepts read/write commands,   |
// |            issues them to the RAM ports and returns read data in order   |
// |            through a 4-entry response FIFO with credit-based flow ctl.   |
// | Ports    : clk, rst            - clock / synchronous active-high reset   |
// |            cmd_*               - command channel (valid/ready)           |
// |            rsp_*               - read-response channel (valid/ready)     |
// |            init_done           - zero-fill finished                      |
// |            ram_ena/wea/addra/dina - RAM write port                       |
// |            ram_enb/addrb/doutb    - RAM read port (1-cycle read latency) |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sram_ctl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  output logic              ram_enb,
  output logic [ADDR_W-1:0] ram_addrb,
  input  logic [DATA_W-1:0] ram_doutb
);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] init_cnt_q;
  logic [DATA_W-1:0] fifo_q [4];
  logic [1:0]        wr_ptr_q;
  logic [1:0]        rd_ptr_q;
  logic [2:0]        fifo_cnt_q;
  logic [2:0]        fifo_cnt_d;
  // One read is outstanding between the acceptance edge and the edge that
  // captures ram_doutb; it must hold a FIFO slot (credit) while in flight.
  logic              rd_pend_q;

  logic              w_run;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [3:0]        w_credits_used;

  assign w_run          = (state_q == S_RUN) && !rst;
  assign w_credits_used = {1'b0, fifo_cnt_q} + {3'b000, rd_pend_q};
  assign cmd_ready      = w_run && (w_credits_used < 4'd4);
  assign w_accept       = cmd_valid && cmd_ready;

  assign init_done = (state_q == S_RUN);
  assign rsp_valid = (fifo_cnt_q != 3'd0);
  assign rsp_rdata = fifo_q[rd_ptr_q];

  assign w_push = rd_pend_q;
  assign w_pop  = rsp_valid && rsp_ready;

  // Write port: zero-fill during INIT, otherwise accepted write commands.
  // Writes go straight to the RAM in the acceptance cycle, so a read accepted
  // on any later cycle observes the new data.
  always_comb begin
    ram_ena   = 1'b0;
    ram_wea   = 1'b0;
    ram_addra = init_cnt_q;
    ram_dina  = '0;
    if (state_q == S_INIT && !rst) begin
      ram_ena = 1'b1;
      ram_wea = 1'b1;
    end else if (w_accept && cmd_we) begin
      ram_ena   = 1'b1;
      ram_wea   = 1'b1;
      ram_addra = cmd_addr;
      ram_dina  = cmd_wdata;
    end
  end

  assign ram_enb   = w_accept && !cmd_we;
  assign ram_addrb = cmd_addr;

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({w_push, w_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      fifo_cnt_q <= 3'd0;
      rd_pend_q  <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          // Counter wraps back to 0 after the last word, leaving it ready
          // for the next reset-triggered fill.
          init_cnt_q <= init_cnt_q + ADDR_W'(1);
          if (&init_cnt_q) begin
            state_q <= S_RUN;
          end
        end
        default: state_q <= S_RUN;
      endcase

      rd_pend_q <= w_accept && !cmd_we;

      // ram_doutb is valid during the cycle after the acceptance edge.
      if (w_push) begin
        fifo_q[wr_ptr_q] <= ram_doutb;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sram_ctl                                                   |
// | Purpose  : Self-checking bench for sram_ctl with a behavioural dual-port |
// |            RAM, a command vector table and a response scoreboard.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sram_ctl;
  localparam int AW = 12;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          ram_ena;
  logic          ram_wea;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dina;
  logic          ram_enb;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_doutb;

  always #5 clk = ~clk;

  sram_ctl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
  );

  // Behavioural RAM: synchronous write, one-cycle registered read.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) ram[ram_addra] <= ram_dina;
    if (ram_enb) ram_doutb <= ram[ram_addrb];
  end

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    bit            lat;
  } sb_t;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  sb_t           sb_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  logic [DW-1:0] pend_exp;
  bit            lat_mode;

  function automatic logic [DW-1:0] pat(int i);
    logic [31:0] hi, lo;
    hi = 32'h5EED_0000 + 32'(i);
    lo = 32'hF00D_0000 ^ 32'(i);
    return {hi, lo};
  endfunction

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample at the falling edge (scoreboard push on read accept,
  // compare on pop), then advance to just after the next rising edge.
  task automatic tick(output bit acc);
    sb_t e;
    @(negedge clk);
    acc = cmd_valid && cmd_ready;
    if (acc && !cmd_we) begin
      e.data = pend_exp;
      e.cyc  = cyc;
      e.lat  = lat_mode;
      sb_q.push_back(e);
    end
    if (rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got %h expected no response", rsp_rdata);
      end else begin
        e = sb_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.data);
        if (e.lat) check("rsp_latency", 64'(cyc - e.cyc), 64'd2);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(int n);
    bit a;
    repeat (n) tick(a);
  endtask

  task automatic issue(bit we, logic [AW-1:0] addr, logic [DW-1:0] wdata, logic [DW-1:0] exp);
    bit acc;
    acc       = 1'b0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    pend_exp  = exp;
    for (int k = 0; k < 50; k++) begin
      tick(acc);
      if (acc) break;
    end
    n_vec++;
    if (!acc) begin
      n_err++;
      $display("FAIL issue_timeout: addr %h not accepted, got ready=0 expected ready=1", addr);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bit a;
    for (int k = 0; k < 30 && sb_q.size() != 0; k++) tick(a);
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic wait_init();
    int n;
    bit a;
    for (n = 0; n < 5000; n++) begin
      #1;
      if (init_done) break;
      if (n == 0) begin
        check("init_first_ena", 64'(ram_ena && ram_wea), 64'd1);
        check("init_first_addr", 64'(ram_addra), 64'd0);
        check("init_first_din", ram_dina, 64'd0);
      end
      if (n == 4095) check("init_last_addr", 64'(ram_addra), 64'd4095);
      tick(a);
    end
    check("init_cycles", 64'(n), 64'd4096);
  endtask

  vec_t vecs[11];

  initial begin
    bit acc;
    int nacc;

    vecs[0]  = '{1'b0, 12'd0,    64'd0,                   64'd0};
    vecs[1]  = '{1'b0, 12'd4095, 64'd0,                   64'd0};
    vecs[2]  = '{1'b1, 12'd0,    64'hABCDABCDABCDABCD,    64'd0};
    vecs[3]  = '{1'b1, 12'd1,    64'hBCDABCDABCDABCDA,    64'd0};
    vecs[4]  = '{1'b0, 12'd0,    64'd0,                   64'hABCDABCDABCDABCD};
    vecs[5]  = '{1'b0, 12'd1,    64'd0,                   64'hBCDABCDABCDABCDA};
    vecs[6]  = '{1'b1, 12'd7,    64'h1234,                64'd0};
    vecs[7]  = '{1'b0, 12'd7,    64'd0,                   64'h1234};
    vecs[8]  = '{1'b1, 12'd4095, 64'h5,                   64'd0};
    vecs[9]  = '{1'b0, 12'd4095, 64'd0,                   64'h5};
    vecs[10] = '{1'b0, 12'd2,    64'd0,                   64'd0};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    pend_exp  = '0;
    lat_mode  = 1'b1;

    // Reset state
    idle(3);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_ram_enb", 64'(ram_enb), 64'd0);
    check("rst_ram_ena", 64'(ram_ena), 64'd0);
    rst = 1'b0;
    wait_init();
    #1;
    check("run_cmd_ready", 64'(cmd_ready), 64'd1);

    // Table-driven commands, issued back to back
    foreach (vecs[i]) issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
    drain();

    // Streaming: 16 back-to-back reads with rsp_ready held high
    for (int i = 0; i < 16; i++) issue(1'b1, AW'(100 + i), pat(i), 64'd0);
    idle(2);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cmd_addr = AW'(100 + i);
      pend_exp = pat(i);
      tick(acc);
      n_vec++;
      if (!acc) begin
        n_err++;
        $display("FAIL stream_accept[%0d]: got ready=0 expected ready=1", i);
      end
    end
    cmd_valid = 1'b0;
    drain();

    // Backpressure: continuous reads with rsp_ready low
    lat_mode  = 1'b0;
    rsp_ready = 1'b0;
    nacc      = 0;
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cmd_addr = AW'(100 + nacc);
      pend_exp = pat(nacc);
      tick(acc);
      if (acc) nacc++;
    end
    cmd_valid = 1'b0;
    #1;
    check("bp_accepted", 64'(nacc), 64'd4);
    check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    drain();
    #1;
    check("bp_ready_back", 64'(cmd_ready), 64'd1);

    // Mid-run reset with three responses queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, AW'(100 + i), 64'd0, pat(i));
    idle(3);
    #1;
    check("mr_queued", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    idle(1);
    #1;
    check("mr_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mr_addra", 64'(ram_addra), 64'd0);
    check("mr_init_done", 64'(init_done), 64'd0);
    check("mr_cmd_ready", 64'(cmd_ready), 64'd0);
    sb_q.delete();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    wait_init();
    lat_mode = 1'b1;
    issue(1'b0, 12'd100, 64'd0, 64'd0);
    drain();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
